midi_voice_alloc: RTL and testbench

Parametrised MIDI note decoder and voice allocator; successor to the single-channel 8-voice decoder. Sits between the MIDI UART byte assembler and the synth engine. Turns note-on, note-off and control-change bytes on a programmable set of MIDI channels into per-voice key gates plus note events. Adds age-ordered voice stealing with selectable policy, note-on velocity 0 treated as note-off, same-note retrigger, and a one-deep byte skid buffer. Fully synchronous to CLOCK_25.

---
 rtl/midi_voice_alloc.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_alloc.sv
// MIDI note decoder and age-ordered voice allocator between the UART byte assembler and the synth engine.
// Optional build macro SUSTAIN_PEDAL_EN adds per-channel CC 64 sustain with held voices.
module midi_voice_alloc #(
  parameter int VOICES     = 8,
  parameter int V_WIDTH    = 3,
  parameter int STEAL_MODE = 0
) (
  input  logic               CLOCK_25,
  input  logic               iRST_N,
  input  logic               byteready,
  input  logic [7:0]         cur_status,
  input  logic [7:0]         midibyte_nr,
  input  logic [7:0]         midibyte,
  input  logic [15:0]        chan_mask,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic               steal,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [3:0]         cur_key_ch,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [V_WIDTH:0]   active_keys,
  output logic               off_note_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D2 = 2'd1;
  localparam logic [1:0] SEARCH  = 2'd2;
  localparam logic [1:0] COMMIT  = 2'd3;

  localparam logic [V_WIDTH-1:0] RANK_ONE = 1;
  localparam logic [V_WIDTH:0]   CNT_ONE  = 1;

  logic [1:0]         state;
  logic               skid_valid;
  logic [7:0]         skid_status, skid_nr, skid_byte;
  logic [7:0]         msg_status, msg_d1, msg_d2;
  logic [7:0]         note_r [VOICES];
  logic [3:0]         ch_r [VOICES];
  logic [V_WIDTH-1:0] rank_r [VOICES];
  logic [VOICES-1:0]  held_r;

  logic       live_ok, proc_valid;
  logic [3:0] live_type;
  logic [7:0] proc_status, proc_nr, proc_byte;

  assign live_type   = cur_status[7:4];
  assign live_ok     = byteready && chan_mask[cur_status[3:0]] &&
                       (live_type == 4'h8 || live_type == 4'h9 || live_type == 4'hB);
  assign proc_valid  = skid_valid || live_ok;
  assign proc_status = skid_valid ? skid_status : cur_status;
  assign proc_nr     = skid_valid ? skid_nr     : midibyte_nr;
  assign proc_byte   = skid_valid ? skid_byte   : midibyte;

  logic [3:0] msg_ch;
  logic       msg_is_on, msg_is_off, msg_all_off, pedal_up, sustained;

  assign msg_ch      = msg_status[3:0];
  assign msg_is_on   = (msg_status[7:4] == 4'h9) && (msg_d2 != 8'h00);
  assign msg_is_off  = (msg_status[7:4] == 4'h8) || ((msg_status[7:4] == 4'h9) && (msg_d2 == 8'h00));
  assign msg_all_off = (msg_status[7:4] == 4'hB) && (msg_d1 == 8'd123);

`ifdef SUSTAIN_PEDAL_EN
  logic [15:0] sustain_r;
  assign sustained = sustain_r[msg_ch];
  assign pedal_up  = (msg_status[7:4] == 4'hB) && (msg_d1 == 8'd64) && (msg_d2 < 8'd64);

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      sustain_r <= '0;
    end else if (state == SEARCH && msg_status[7:4] == 4'hB) begin
      if (msg_d1 == 8'd64)       sustain_r[msg_ch] <= (msg_d2 >= 8'd64);
      else if (msg_d1 == 8'd123) sustain_r <= '0;
    end
  end
`else
  assign sustained = 1'b0;
  assign pedal_up  = 1'b0;
`endif

  // Bytes arriving while a message is being resolved wait in the skid register.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      skid_valid  <= 1'b0;
      skid_status <= '0;
      skid_nr     <= '0;
      skid_byte   <= '0;
      msg_status  <= '0;
      msg_d1      <= '0;
      msg_d2      <= '0;
    end else begin
      if (state == IDLE || state == WAIT_D2) begin
        if (skid_valid) skid_valid <= live_ok;
        if (skid_valid && live_ok) begin
          skid_status <= cur_status;
          skid_nr     <= midibyte_nr;
          skid_byte   <= midibyte;
        end
      end else if (live_ok && !skid_valid) begin
        skid_valid  <= 1'b1;
        skid_status <= cur_status;
        skid_nr     <= midibyte_nr;
        skid_byte   <= midibyte;
      end

      case (state)
        IDLE: begin
          if (proc_valid && proc_nr == 8'd1) begin
            msg_status <= proc_status;
            msg_d1     <= proc_byte;
            state      <= WAIT_D2;
          end
        end
        WAIT_D2: begin
          if (proc_valid && proc_nr == 8'd1) begin
            msg_status <= proc_status;
            msg_d1     <= proc_byte;
          end else if (proc_valid && proc_nr == 8'd2) begin
            msg_d2 <= proc_byte;
            state  <= SEARCH;
          end
        end
        SEARCH:  state <= COMMIT;
        default: state <= IDLE;
      endcase
    end
  end

  logic [VOICES-1:0]  keys_nxt, held_nxt, rel_mask;
  logic [7:0]         note_nxt [VOICES];
  logic [3:0]         ch_nxt [VOICES];
  logic [V_WIDTH-1:0] rank_nxt [VOICES];
  logic [V_WIDTH:0]   active_nxt, rel_cnt;
  logic [V_WIDTH-1:0] tgt, match_idx, free_idx, idle_idx, old_idx, dec;
  logic               match_hit, free_hit, idle_hit, do_on, do_off, do_steal, set_err;

  // Rank 0 is the oldest gated voice; releases and steals close the gap so ranks stay dense.
  always_comb begin
    keys_nxt   = keys_on;
    held_nxt   = held_r;
    active_nxt = active_keys;
    note_nxt   = note_r;
    ch_nxt     = ch_r;
    rank_nxt   = rank_r;
    rel_mask   = '0;
    rel_cnt    = '0;
    dec        = '0;
    tgt        = '0;
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    idle_hit   = 1'b0;
    idle_idx   = '0;
    old_idx    = '0;
    do_on      = 1'b0;
    do_off     = 1'b0;
    do_steal   = 1'b0;
    set_err    = 1'b0;

    for (int i = VOICES - 1; i >= 0; i--) begin
      if (keys_on[i] && note_r[i] == msg_d1 && ch_r[i] == msg_ch) begin
        match_hit = 1'b1;
        match_idx = V_WIDTH'(i);
      end
      if (!keys_on[i] && voice_free[i]) begin
        free_hit = 1'b1;
        free_idx = V_WIDTH'(i);
      end
      if (!keys_on[i]) begin
        idle_hit = 1'b1;
        idle_idx = V_WIDTH'(i);
      end
      if (keys_on[i] && rank_r[i] == '0) old_idx = V_WIDTH'(i);
    end

    if (msg_is_on) begin
      if (match_hit) begin
        for (int j = 0; j < VOICES; j++)
          if (keys_on[j] && rank_r[j] > rank_r[match_idx]) rank_nxt[j] = rank_r[j] - RANK_ONE;
        rank_nxt[match_idx] = V_WIDTH'(active_keys - CNT_ONE);
        held_nxt[match_idx] = 1'b0;
        tgt   = match_idx;
        do_on = 1'b1;
      end else if (idle_hit) begin
        tgt            = free_hit ? free_idx : idle_idx;
        keys_nxt[tgt]  = 1'b1;
        note_nxt[tgt]  = msg_d1;
        ch_nxt[tgt]    = msg_ch;
        rank_nxt[tgt]  = V_WIDTH'(active_keys);
        held_nxt[tgt]  = 1'b0;
        active_nxt     = active_keys + CNT_ONE;
        do_on          = 1'b1;
      end else if (STEAL_MODE == 0) begin
        tgt = old_idx;
        for (int j = 0; j < VOICES; j++) rank_nxt[j] = rank_r[j] - RANK_ONE;
        rank_nxt[tgt] = V_WIDTH'(VOICES - 1);
        note_nxt[tgt] = msg_d1;
        ch_nxt[tgt]   = msg_ch;
        held_nxt[tgt] = 1'b0;
        do_on         = 1'b1;
        do_steal      = 1'b1;
      end
    end else if (msg_is_off) begin
      if (!match_hit)     set_err = 1'b1;
      else if (sustained) held_nxt[match_idx] = 1'b1;
      else                rel_mask[match_idx] = 1'b1;
    end else if (pedal_up) begin
      for (int j = 0; j < VOICES; j++)
        if (held_r[j] && ch_r[j] == msg_ch) rel_mask[j] = 1'b1;
    end

    for (int i = VOICES - 1; i >= 0; i--) begin
      if (rel_mask[i]) begin
        rel_cnt = rel_cnt + CNT_ONE;
        tgt     = V_WIDTH'(i);
      end
    end

    if (rel_mask != '0) begin
      for (int j = 0; j < VOICES; j++) begin
        if (rel_mask[j]) begin
          keys_nxt[j] = 1'b0;
          note_nxt[j] = 8'hFF;
          rank_nxt[j] = '0;
          held_nxt[j] = 1'b0;
        end else if (keys_on[j]) begin
          dec = '0;
          for (int k = 0; k < VOICES; k++)
            if (rel_mask[k] && rank_r[k] < rank_r[j]) dec = dec + RANK_ONE;
          rank_nxt[j] = rank_r[j] - dec;
        end
      end
      active_nxt = active_keys - rel_cnt;
      do_off     = 1'b1;
    end

    if (msg_all_off) begin
      keys_nxt   = '0;
      held_nxt   = '0;
      active_nxt = '0;
      for (int j = 0; j < VOICES; j++) begin
        note_nxt[j] = 8'hFF;
        rank_nxt[j] = '0;
      end
      tgt    = '0;
      do_off = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      keys_on        <= '0;
      held_r         <= '0;
      active_keys    <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_r[i] <= 8'hFF;
        ch_r[i]   <= '0;
        rank_r[i] <= '0;
      end
      note_on        <= 1'b0;
      note_off       <= 1'b0;
      steal          <= 1'b0;
      cur_key_adr    <= '0;
      cur_key_val    <= 8'hFF;
      cur_key_ch     <= '0;
      cur_vel_on     <= '0;
      cur_vel_off    <= '0;
      off_note_error <= 1'b0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      steal    <= 1'b0;
      if (state == SEARCH) begin
        keys_on     <= keys_nxt;
        held_r      <= held_nxt;
        active_keys <= active_nxt;
        note_r      <= note_nxt;
        ch_r        <= ch_nxt;
        rank_r      <= rank_nxt;
        note_on     <= do_on;
        note_off    <= do_off;
        steal       <= do_steal;
        if (set_err)          off_note_error <= 1'b1;
        else if (msg_all_off) off_note_error <= 1'b0;
        if (do_on) begin
          cur_key_adr <= tgt;
          cur_key_val <= msg_d1;
          cur_key_ch  <= msg_ch;
          cur_vel_on  <= msg_d2;
        end else if (do_off) begin
          cur_key_adr <= tgt;
          cur_key_val <= 8'hFF;
          cur_key_ch  <= msg_ch;
          if (msg_is_off) cur_vel_off <= msg_d2;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: stimulus pushes hand-computed events, a negedge monitor pops them on each pulse.
// A second instance with STEAL_MODE=1 is checked directly during the full-polyphony test.
module tb_midi_voice_alloc;

  logic        CLOCK_25 = 1'b0;
  logic        iRST_N;
  logic        byteready;
  logic [7:0]  cur_status, midibyte_nr, midibyte;
  logic [15:0] chan_mask;
  logic [7:0]  voice_free;

  logic [7:0]  keys_on, cur_key_val, cur_vel_on, cur_vel_off;
  logic        note_on, note_off, steal, off_note_error;
  logic [2:0]  cur_key_adr;
  logic [3:0]  cur_key_ch, active_keys;

  logic [7:0]  d_keys_on, d_cur_key_val, d_cur_vel_on, d_cur_vel_off;
  logic        d_note_on, d_note_off, d_steal, d_off_note_error;
  logic [2:0]  d_cur_key_adr;
  logic [3:0]  d_cur_key_ch, d_active_keys;

  int errors = 0;
  int checks = 0;
  int drop_on_cnt = 0;
  int drop_steal_cnt = 0;

  typedef struct {
    bit         is_off;
    bit         stl;
    logic [2:0] adr;
    logic [7:0] val;
    logic [3:0] ch;
    logic [7:0] keys;
    logic [3:0] act;
    bit         chk_vel;
    logic [7:0] vel;
  } exp_t;

  exp_t sb_q[$];

  midi_voice_alloc #(.VOICES(8), .V_WIDTH(3), .STEAL_MODE(0)) dut (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .byteready(byteready),
    .cur_status(cur_status), .midibyte_nr(midibyte_nr), .midibyte(midibyte),
    .chan_mask(chan_mask), .voice_free(voice_free), .keys_on(keys_on),
    .note_on(note_on), .note_off(note_off), .steal(steal),
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val), .cur_key_ch(cur_key_ch),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off), .active_keys(active_keys),
    .off_note_error(off_note_error)
  );

  midi_voice_alloc #(.VOICES(8), .V_WIDTH(3), .STEAL_MODE(1)) dut_drop (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .byteready(byteready),
    .cur_status(cur_status), .midibyte_nr(midibyte_nr), .midibyte(midibyte),
    .chan_mask(chan_mask), .voice_free(voice_free), .keys_on(d_keys_on),
    .note_on(d_note_on), .note_off(d_note_off), .steal(d_steal),
    .cur_key_adr(d_cur_key_adr), .cur_key_val(d_cur_key_val), .cur_key_ch(d_cur_key_ch),
    .cur_vel_on(d_cur_vel_on), .cur_vel_off(d_cur_vel_off), .active_keys(d_active_keys),
    .off_note_error(d_off_note_error)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expOn(input logic [2:0] adr, input logic [7:0] val, input logic [3:0] ch,
                       input logic [7:0] keys, input logic [3:0] act, input logic [7:0] vel, input bit stl);
    exp_t e;
    e.is_off = 1'b0; e.stl = stl; e.adr = adr; e.val = val; e.ch = ch;
    e.keys = keys; e.act = act; e.chk_vel = 1'b1; e.vel = vel;
    sb_q.push_back(e);
  endtask

  task automatic expOff(input logic [2:0] adr, input logic [3:0] ch, input logic [7:0] keys,
                        input logic [3:0] act, input bit chk_vel, input logic [7:0] vel);
    exp_t e;
    e.is_off = 1'b1; e.stl = 1'b0; e.adr = adr; e.val = 8'hFF; e.ch = ch;
    e.keys = keys; e.act = act; e.chk_vel = chk_vel; e.vel = vel;
    sb_q.push_back(e);
  endtask

  // Monitor: every note_on/note_off pulse must match the oldest queued expectation.
  bit prev_pulse = 1'b0;
  always @(negedge CLOCK_25) begin
    exp_t e;
    if (iRST_N && (note_on || note_off)) begin
      checkOutput("pulse_width", 32'(prev_pulse), 32'd0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, note_on, note_off}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("note_on", 32'(note_on), 32'(!e.is_off));
        checkOutput("note_off", 32'(note_off), 32'(e.is_off));
        checkOutput("steal", 32'(steal), 32'(e.stl));
        checkOutput("cur_key_adr", 32'(cur_key_adr), 32'(e.adr));
        checkOutput("cur_key_val", 32'(cur_key_val), 32'(e.val));
        checkOutput("cur_key_ch", 32'(cur_key_ch), 32'(e.ch));
        checkOutput("keys_on", 32'(keys_on), 32'(e.keys));
        checkOutput("active_keys", 32'(active_keys), 32'(e.act));
        if (e.chk_vel && !e.is_off) checkOutput("cur_vel_on", 32'(cur_vel_on), 32'(e.vel));
        if (e.chk_vel && e.is_off)  checkOutput("cur_vel_off", 32'(cur_vel_off), 32'(e.vel));
      end
    end
    prev_pulse = iRST_N && (note_on || note_off);
  end

  always @(negedge CLOCK_25) begin
    if (!iRST_N) begin
      drop_on_cnt    = 0;
      drop_steal_cnt = 0;
    end else begin
      if (d_note_on) drop_on_cnt++;
      if (d_steal)   drop_steal_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_25);
  endtask

  task automatic sendByte(input logic [7:0] st, input logic [7:0] nr, input logic [7:0] val);
    cur_status  = st;
    midibyte_nr = nr;
    midibyte    = val;
    byteready   = 1'b1;
    @(negedge CLOCK_25);
    byteready   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
    sendByte(st, 8'd1, d1);
    sendByte(st, 8'd2, d2);
    idle(3);
  endtask

  task automatic doReset();
    byteready = 1'b0;
    iRST_N    = 1'b0;
    idle(2);
    iRST_N    = 1'b1;
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] k;
    cur_status = '0; midibyte_nr = '0; midibyte = '0; byteready = 1'b0;
    chan_mask = 16'h0001; voice_free = 8'hFF; iRST_N = 1'b1;
    @(negedge CLOCK_25);
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_keys_on", 32'(keys_on), 32'h00);
    checkOutput("rst_active_keys", 32'(active_keys), 32'h0);
    checkOutput("rst_cur_key_val", 32'(cur_key_val), 32'hFF);
    checkOutput("rst_off_note_error", 32'(off_note_error), 32'h0);
    checkOutput("rst_note_on", 32'(note_on), 32'h0);
    checkOutput("rst_cur_key_adr", 32'(cur_key_adr), 32'h0);
    checkOutput("rst_cur_vel_on", 32'(cur_vel_on), 32'h0);

    $display("[TB] note on / off / error");
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h64);
    expOff(3'd0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h40);
    applyStimulus(8'h80, 8'h3C, 8'h40);
    applyStimulus(8'h80, 8'h3C, 8'h40);
    checkOutput("off_note_error_set", 32'(off_note_error), 32'h1);

    $display("[TB] velocity zero and retrigger");
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h64);
    expOff(3'd0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h00);
    applyStimulus(8'h90, 8'h3C, 8'h00);
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h64);
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h70, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h70);
    expOff(3'd0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h00);
    applyStimulus(8'hB0, 8'd123, 8'h00);
    checkOutput("all_off_clears_error", 32'(off_note_error), 32'h0);

    $display("[TB] channel mask");
    applyStimulus(8'h92, 8'h3C, 8'h64);
    checkOutput("masked_keys_on", 32'(keys_on), 32'h00);
    checkOutput("masked_active", 32'(active_keys), 32'h0);
    chan_mask = 16'h0005;
    expOn(3'd0, 8'h3D, 4'd2, 8'h01, 4'd1, 8'h50, 1'b0);
    applyStimulus(8'h92, 8'h3D, 8'h50);
    expOff(3'd0, 4'd2, 8'h00, 4'd0, 1'b1, 8'h00);
    applyStimulus(8'hB2, 8'd123, 8'h00);
    chan_mask = 16'h0001;

    $display("[TB] all notes off and voice_free preference");
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h64);
    expOn(3'd1, 8'h3D, 4'd0, 8'h03, 4'd2, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3D, 8'h64);
    expOn(3'd2, 8'h3E, 4'd0, 8'h07, 4'd3, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3E, 8'h64);
    expOff(3'd0, 4'd0, 8'h06, 4'd2, 1'b1, 8'h40);
    applyStimulus(8'h80, 8'h3C, 8'h40);
    voice_free = 8'hFE;
    expOn(3'd3, 8'h3F, 4'd0, 8'h0E, 4'd3, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3F, 8'h64);
    voice_free = 8'h00;
    expOn(3'd0, 8'h40, 4'd0, 8'h0F, 4'd4, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h40, 8'h64);
    voice_free = 8'hFF;
    expOff(3'd0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h40);
    applyStimulus(8'hB0, 8'd123, 8'h00);

    $display("[TB] full polyphony, steal and drop");
    doReset();
    for (int i = 0; i < 8; i++) begin
      k = (9'd1 << (i + 1)) - 9'd1;
      expOn(3'(i), 8'(8'h3C + i), 4'd0, k[7:0], 4'(i + 1), 8'h64, 1'b0);
      applyStimulus(8'h90, 8'(8'h3C + i), 8'h64);
    end
    expOn(3'd0, 8'h44, 4'd0, 8'hFF, 4'd8, 8'h64, 1'b1);
    applyStimulus(8'h90, 8'h44, 8'h64);
    checkOutput("drop_on_count", 32'(drop_on_cnt), 32'd8);
    checkOutput("drop_steal_count", 32'(drop_steal_cnt), 32'd0);
    checkOutput("drop_keys_on", 32'(d_keys_on), 32'hFF);
    checkOutput("drop_active", 32'(d_active_keys), 32'd8);
    checkOutput("drop_key_val", 32'(d_cur_key_val), 32'h43);
    expOn(3'd1, 8'h45, 4'd0, 8'hFF, 4'd8, 8'h64, 1'b1);
    applyStimulus(8'h90, 8'h45, 8'h64);
    checkOutput("drop_on_count2", 32'(drop_on_cnt), 32'd8);
    expOff(3'd2, 4'd0, 8'hFB, 4'd7, 1'b1, 8'h40);
    applyStimulus(8'h80, 8'h3E, 8'h40);
    expOn(3'd2, 8'h46, 4'd0, 8'hFF, 4'd8, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h46, 8'h64);
    expOn(3'd3, 8'h47, 4'd0, 8'hFF, 4'd8, 8'h64, 1'b1);
    applyStimulus(8'h90, 8'h47, 8'h64);

    $display("[TB] reset mid-message");
    doReset();
    sendByte(8'h90, 8'd1, 8'h3C);
    doReset();
    sendByte(8'h90, 8'd2, 8'h64);
    idle(3);
    checkOutput("orphan_d2_keys_on", 32'(keys_on), 32'h00);
    expOn(3'd0, 8'h3D, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3D, 8'h64);

    $display("[TB] skid capture and overflow drop");
    doReset();
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    expOn(3'd1, 8'h3D, 4'd0, 8'h03, 4'd2, 8'h55, 1'b0);
    sendByte(8'h90, 8'd1, 8'h3C);
    sendByte(8'h90, 8'd2, 8'h64);
    sendByte(8'h90, 8'd1, 8'h3D);
    sendByte(8'h90, 8'd2, 8'h50);
    idle(2);
    sendByte(8'h90, 8'd2, 8'h55);
    idle(3);
    checkOutput("skid_active", 32'(active_keys), 32'd2);

`ifdef SUSTAIN_PEDAL_EN
    $display("[TB] sustain pedal");
    doReset();
    applyStimulus(8'hB0, 8'd64, 8'h7F);
    expOn(3'd0, 8'h3C, 4'd0, 8'h01, 4'd1, 8'h64, 1'b0);
    applyStimulus(8'h90, 8'h3C, 8'h64);
    applyStimulus(8'h80, 8'h3C, 8'h40);
    checkOutput("held_keys_on", 32'(keys_on), 32'h01);
    checkOutput("held_active", 32'(active_keys), 32'd1);
    expOff(3'd0, 4'd0, 8'h00, 4'd0, 1'b0, 8'h00);
    applyStimulus(8'hB0, 8'd64, 8'h00);
`endif

    idle(2);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
